// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/rdy fetch
// to instruction memory and loads the IF/ID pipeline register.
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] INS_NOP  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWr,
   input  logic        IFIDWr,
   input  logic        IFIDFlush,
   input  logic        NPCSel,
   input  logic [31:0] NPC,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_rdy,
   input  logic [31:0] im_rdata,
   output logic [31:0] PC,
   output logic [31:0] IFIDPC,
   output logic [31:0] IFIDPCPLUS4,
   output logic [31:0] IFIDIns,
   output logic        IFIDValid,
   output logic [31:0] BubbleCnt
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] skid;
   logic [XLEN-1:0] drop_addr;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] word;
   logic            redirect;
   logic            have_word;
   logic            advance;
   logic            bubble;

   assign redirect  = NPCSel & PCWr;
   assign pc_plus4  = PC + XLEN'(4);
   // A real instruction is available from the skid buffer or a live (non-cancelled) response
   assign have_word = (state == S_HOLD) | ((state == S_REQ) & im_rdy);
   assign word      = (state == S_HOLD) ? skid : im_rdata;
   assign advance   = have_word & ~redirect & ~IFIDFlush & IFIDWr & PCWr;
   assign bubble    = ~advance & (IFIDWr | IFIDFlush);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REQ: begin
            if (redirect) begin
               state_nxt = im_rdy ? S_REQ : S_DROP;
            end else if (im_rdy & ~advance) begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect | advance) begin
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (im_rdy) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   // Memory request outputs; a cancelled request keeps presenting its original address
   always_comb begin
      im_req  = 1'b0;
      im_addr = PC;
      unique case (state)
         S_REQ:   im_req = ~rst;
         S_DROP: begin
            im_req  = ~rst;
            im_addr = drop_addr;
         end
         default: im_req = 1'b0;
      endcase
   end

   // PC, skid buffer, IF/ID register and bubble counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC          <= PC_RESET;
         skid        <= INS_NOP;
         drop_addr   <= '0;
         IFIDPC      <= '0;
         IFIDPCPLUS4 <= '0;
         IFIDIns     <= INS_NOP;
         IFIDValid   <= 1'b0;
         BubbleCnt   <= '0;
      end else begin
         if (redirect) begin
            PC <= NPC & ~XLEN'(3);
         end else if (advance) begin
            PC <= pc_plus4;
         end

         if ((state == S_REQ) & im_rdy & ~advance & ~redirect) begin
            skid <= im_rdata;
         end

         if ((state == S_REQ) & redirect & ~im_rdy) begin
            drop_addr <= PC;
         end

         if (advance) begin
            IFIDPC      <= PC;
            IFIDPCPLUS4 <= pc_plus4;
            IFIDIns     <= word;
            IFIDValid   <= 1'b1;
         end else if (bubble) begin
            IFIDIns     <= INS_NOP;
            IFIDValid   <= 1'b0;
         end

         if (bubble && (BubbleCnt != '1)) begin
            BubbleCnt <= BubbleCnt + XLEN'(1);
         end
      end
   end

endmodule
